// File: rtl/pipe_mux_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_mux_reg
// Purpose  : N:1 select mux feeding a DEPTH-stage valid-tagged pipeline with
//            stall/flush control and out-of-range select logging.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_mux_reg #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 3,
    parameter int SEL_W  = 2,
    parameter int DEPTH  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    input  logic                    stall,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    output logic                    sel_err,
    output logic [7:0]              err_count
);

    localparam logic [7:0] c_err_max = 8'hFF;

    logic [WIDTH-1:0] w_mux_out;
    logic             w_sel_oor;
    logic             w_log_err;

    logic [WIDTH-1:0] r_data  [DEPTH];
    logic             r_valid [DEPTH];
    logic             r_sel_err;
    logic [7:0]       r_err_count;

    // Unselected or out-of-range codes yield zero, like the legacy 3:1 mux.
    always_comb begin
        w_mux_out = '0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (32'(sel) == k) begin
                w_mux_out = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    generate
        if (NUM_IN < (2 ** SEL_W)) begin : g_oor_check
            assign w_sel_oor = (32'(sel) >= 32'(NUM_IN));
        end else begin : g_oor_none
            assign w_sel_oor = 1'b0;
        end
    endgenerate

    assign w_log_err = !stall && !flush && in_valid && w_sel_oor;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i]  <= '0;
                r_valid[i] <= 1'b0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i]  <= '0;
                r_valid[i] <= 1'b0;
            end
        end else if (!stall) begin
            r_data[0]  <= w_mux_out;
            r_valid[0] <= in_valid;
            for (int i = 1; i < DEPTH; i++) begin
                r_data[i]  <= r_data[i-1];
                r_valid[i] <= r_valid[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel_err   <= 1'b0;
            r_err_count <= 8'h00;
        end else if (w_log_err) begin
            r_sel_err <= 1'b1;
            if (r_err_count != c_err_max) begin
                r_err_count <= r_err_count + 8'h01;
            end
        end
    end

    assign out_data  = r_data[DEPTH-1];
    assign out_valid = r_valid[DEPTH-1];
    assign sel_err   = r_sel_err;
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_pipe_mux_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_mux_reg
// Purpose  : Directed bench for pipe_mux_reg in three configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_mux_reg;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] in_data4;
    logic [95:0]  in_data3;
    logic [1:0]   sel;
    logic         in_valid;
    logic         stall;
    logic         flush;

    logic [31:0] d1_data, d3_data, d4_data;
    logic        d1_valid, d3_valid, d4_valid;
    logic        d1_err, d3_err, d4_err;
    logic [7:0]  d1_cnt, d3_cnt, d4_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign in_data3 = in_data4[95:0];

    pipe_mux_reg #(.WIDTH(32), .NUM_IN(3), .SEL_W(2), .DEPTH(1)) dut1 (
        .clk(clk), .reset(reset), .in_data(in_data3), .sel(sel),
        .in_valid(in_valid), .stall(stall), .flush(flush),
        .out_data(d1_data), .out_valid(d1_valid), .sel_err(d1_err), .err_count(d1_cnt));

    pipe_mux_reg #(.WIDTH(32), .NUM_IN(3), .SEL_W(2), .DEPTH(3)) dut3 (
        .clk(clk), .reset(reset), .in_data(in_data3), .sel(sel),
        .in_valid(in_valid), .stall(stall), .flush(flush),
        .out_data(d3_data), .out_valid(d3_valid), .sel_err(d3_err), .err_count(d3_cnt));

    pipe_mux_reg #(.WIDTH(32), .NUM_IN(4), .SEL_W(2), .DEPTH(1)) dut4 (
        .clk(clk), .reset(reset), .in_data(in_data4), .sel(sel),
        .in_valid(in_valid), .stall(stall), .flush(flush),
        .out_data(d4_data), .out_valid(d4_valid), .sel_err(d4_err), .err_count(d4_cnt));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] s, input logic v, input logic st, input logic fl);
        sel      = s;
        in_valid = v;
        stall    = st;
        flush    = fl;
    endtask

    initial begin
        reset    = 1'b1;
        in_data4 = {32'h44, 32'h33, 32'h22, 32'h11};
        drive(2'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        check("rst_data",  d1_data, 32'h0);
        check("rst_valid", {31'b0, d1_valid}, 32'h0);
        check("rst_err",   {31'b0, d1_err}, 32'h0);
        check("rst_cnt",   {24'b0, d1_cnt}, 32'h0);

        // Basic select, then asynchronous reset in the middle of a cycle
        drive(2'd1, 1'b1, 1'b0, 1'b0);
        step();
        check("sel1_data",  d1_data, 32'h22);
        check("sel1_valid", {31'b0, d1_valid}, 32'h1);
        check("sel1_d4",    d4_data, 32'h22);
        #2 reset = 1'b1;
        #1;
        check("async_rst_data",  d1_data, 32'h0);
        check("async_rst_valid", {31'b0, d1_valid}, 32'h0);
        reset = 1'b0;

        // Out-of-range select
        drive(2'd3, 1'b1, 1'b0, 1'b0);
        step();
        check("oor_data",  d1_data, 32'h0);
        check("oor_valid", {31'b0, d1_valid}, 32'h1);
        check("oor_err",   {31'b0, d1_err}, 32'h1);
        check("oor_cnt",   {24'b0, d1_cnt}, 32'h1);
        check("oor_d4_data", d4_data, 32'h44);
        check("oor_d4_err",  {31'b0, d4_err}, 32'h0);
        drive(2'd3, 1'b0, 1'b0, 1'b0);
        step();
        check("oor_inv_cnt",   {24'b0, d1_cnt}, 32'h1);
        check("oor_inv_valid", {31'b0, d1_valid}, 32'h0);
        drive(2'd3, 1'b1, 1'b1, 1'b0);
        step();
        check("oor_stall_cnt", {24'b0, d1_cnt}, 32'h1);
        drive(2'd3, 1'b1, 1'b0, 1'b1);
        step();
        check("oor_flush_cnt", {24'b0, d1_cnt}, 32'h1);

        // Stall hold with DEPTH=3: A, B, stall x2, C
        drive(2'd0, 1'b1, 1'b0, 1'b0);
        step();
        check("st_e1_v3", {31'b0, d3_valid}, 32'h0);
        drive(2'd1, 1'b1, 1'b0, 1'b0);
        step();
        check("st_e2_v3", {31'b0, d3_valid}, 32'h0);
        check("st_e2_d1", d1_data, 32'h22);
        drive(2'd2, 1'b1, 1'b1, 1'b0);
        step();
        check("st_e3_v3",  {31'b0, d3_valid}, 32'h0);
        check("st_e3_d1",  d1_data, 32'h22);
        check("st_e3_d1v", {31'b0, d1_valid}, 32'h1);
        step();
        check("st_e4_v3", {31'b0, d3_valid}, 32'h0);
        check("st_e4_d1", d1_data, 32'h22);
        drive(2'd2, 1'b1, 1'b0, 1'b0);
        step();
        check("st_e5_d3", d3_data, 32'h11);
        check("st_e5_v3", {31'b0, d3_valid}, 32'h1);
        check("st_e5_d1", d1_data, 32'h33);
        drive(2'd0, 1'b0, 1'b0, 1'b0);
        step();
        check("st_e6_d3", d3_data, 32'h22);
        check("st_e6_v3", {31'b0, d3_valid}, 32'h1);
        step();
        check("st_e7_d3", d3_data, 32'h33);
        check("st_e7_v3", {31'b0, d3_valid}, 32'h1);
        step();
        check("st_e8_v3", {31'b0, d3_valid}, 32'h0);

        // Flush beats stall and drops the presented input
        drive(2'd0, 1'b1, 1'b0, 1'b0);
        step();
        drive(2'd1, 1'b1, 1'b0, 1'b0);
        step();
        drive(2'd2, 1'b1, 1'b0, 1'b0);
        step();
        check("fl_loaded", d3_data, 32'h11);
        drive(2'd1, 1'b1, 1'b1, 1'b1);
        step();
        check("fl_f4_data",  d3_data, 32'h0);
        check("fl_f4_valid", {31'b0, d3_valid}, 32'h0);
        drive(2'd0, 1'b0, 1'b0, 1'b0);
        step();
        check("fl_f5_data",  d3_data, 32'h0);
        check("fl_f5_valid", {31'b0, d3_valid}, 32'h0);
        step();
        check("fl_f6_data",  d3_data, 32'h0);
        check("fl_f6_valid", {31'b0, d3_valid}, 32'h0);
        step();
        check("fl_f7_valid", {31'b0, d3_valid}, 32'h0);
        check("fl_f7_data",  d3_data, 32'h11);

        // Saturation: 300 more logged errors on top of the one already counted
        drive(2'd3, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 253; i++) step();
        check("sat_254", {24'b0, d1_cnt}, 32'd254);
        for (int i = 0; i < 47; i++) step();
        check("sat_255",    {24'b0, d1_cnt}, 32'd255);
        check("sat_d3_255", {24'b0, d3_cnt}, 32'd255);
        step();
        check("sat_hold", {24'b0, d1_cnt}, 32'd255);
        check("sat_d4_err", {31'b0, d4_err}, 32'h0);
        check("sat_d4_cnt", {24'b0, d4_cnt}, 32'h0);
        drive(2'd0, 1'b0, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("sat_rst_cnt", {24'b0, d1_cnt}, 32'h0);
        check("sat_rst_err", {31'b0, d1_err}, 32'h0);
        reset = 1'b0;

        // Full decode, NUM_IN = 4
        for (int s = 0; s < 4; s++) begin
            drive(2'(s), 1'b1, 1'b0, 1'b0);
            step();
            check($sformatf("dec_data%0d", s), d4_data, 32'h11 * (s + 1));
            check($sformatf("dec_valid%0d", s), {31'b0, d4_valid}, 32'h1);
            check($sformatf("dec_err%0d", s), {31'b0, d4_err}, 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
